// File: rtl/serial_receiver_if.sv
// Handshake bundle between the serial receiver and its consumer: serial line in,
// received byte out over req/data/ack, plus single-cycle status pulses.
`timescale 1ns/1ps

interface serial_receiver_if;
  logic       rx;
  logic       req;
  logic [7:0] data;
  logic       ack;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  // The receiver end produces bytes and status; the consumer end drives the line and ack.
  modport slave  (input  rx, ack,
                  output req, data, frame_err, parity_err, overrun);
  modport master (output rx, ack,
                  input  req, data, frame_err, parity_err, overrun);
endinterface

// File: rtl/serial_receiver.sv
// UART receiver: 8 data bits LSB first, 1 stop bit, req/data/ack output handshake.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit between data bit 7 and the stop bit.
`timescale 1ns/1ps

module serial_receiver #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic               clk,
  input  logic               rst,
  serial_receiver_if.slave   bus_io
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TIMER_W      = $clog2(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] HALF_T = TIMER_W'(HALF_BIT);
  localparam logic [TIMER_W-1:0] LAST_T = TIMER_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("serial_receiver: CLK_HZ/BAUD must be at least 4");
    end
  endgenerate

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;
`endif

  state_e               state_q, state_d;
  logic [1:0]           sync_q;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           data_q, data_d;
  logic                 req_q, req_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_s;
  logic                 bit_end;
  logic                 par_bad;
`ifdef SERIAL_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
  assign par_bad = par_bad_q;
`else
  assign par_bad = 1'b0;
`endif

  assign rx_s    = sync_q[1];
  assign bit_end = (timer_q == LAST_T);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    timer_d     = timer_q + TIMER_W'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    req_d       = req_q && !bus_io.ack;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        timer_d   = '0;
        bit_idx_d = '0;
`ifdef SERIAL_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!rx_s) state_d = START;
      end
      START: begin
        // Restarting the timer at mid-start-bit puts every later sample at a bit centre.
        if (timer_q == HALF_T) begin
          timer_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d        = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          timer_d   = '0;
          par_bad_d = (^shift_q) ^ rx_s;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          timer_d = '0;
          if (!rx_s) begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end else begin
            state_d = IDLE;
            if (par_bad) begin
`ifdef SERIAL_RX_PARITY_EN
              parity_err_d = 1'b1;
`endif
            end else if (req_q) begin
              // A same-cycle ack still counts as occupied: the new byte is dropped.
              overrun_d = 1'b1;
            end else begin
              data_d = shift_q;
              req_d  = 1'b1;
            end
          end
        end
      end
      BREAK: begin
        timer_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      req_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q      <= {sync_q[0], bus_io.rx};
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      req_q       <= req_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef SERIAL_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus_io.req       = req_q;
  assign bus_io.data      = data_q;
  assign bus_io.frame_err = frame_err_q;
  assign bus_io.overrun   = overrun_q;
`ifdef SERIAL_RX_PARITY_EN
  assign bus_io.parity_err = parity_err_q;
`else
  assign bus_io.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver at 10 clocks/bit; a frame-level model predicts
// the outcome of every frame and a per-cycle monitor checks held data and pulse shape.
`timescale 1ns/1ps

module tb_serial_receiver;
  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int CPB    = 10;
`ifdef SERIAL_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  // rx fall to req rise: 2 sync + half bit + 9/10 bit periods + 1 register stage
  localparam int EXP_LAT = 2 + CPB / 2 + (PAR ? 10 : 9) * CPB + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_receiver_if bus ();

  serial_receiver #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level model: last byte the consumer should see, and whether it is still unacked.
  logic [7:0] model_data = 8'h00;
  bit         model_pending = 1'b0;

  int   cycle = 0;
  int   n_req_rise = 0, n_req_cycles = 0, n_fe = 0, n_pe = 0, n_ov = 0;
  int   last_rise_cycle = 0;
  logic prev_req = 1'b0, prev_fe = 1'b0, prev_pe = 1'b0, prev_ov = 1'b0;

  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      check("reset_outputs",
            {19'd0, bus.req, bus.data, bus.frame_err, bus.parity_err, bus.overrun}, 32'd0);
    end else begin
      if (bus.req) begin
        n_req_cycles++;
        check("data_while_req", {24'd0, bus.data}, {24'd0, model_data});
        if (!prev_req) begin
          n_req_rise++;
          last_rise_cycle = cycle;
        end
      end
      if (bus.frame_err || bus.parity_err || bus.overrun)
        check("pulse_width",
              {29'd0, prev_fe & bus.frame_err, prev_pe & bus.parity_err, prev_ov & bus.overrun}, 32'd0);
      if (bus.frame_err)  n_fe++;
      if (bus.parity_err) n_pe++;
      if (bus.overrun)    n_ov++;
    end
    prev_req = bus.req;
    prev_fe  = bus.frame_err;
    prev_pe  = bus.parity_err;
    prev_ov  = bus.overrun;
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bus.rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic [7:0] b, input logic par_v, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR) drive_bit(par_v);
    drive_bit(stop_v);
  endtask

  function automatic int total_events();
    return n_req_rise + n_fe + n_pe + n_ov;
  endfunction

  // Sends one frame, predicts its single outcome from the framing rules, checks event counts.
  task automatic do_frame(input string tag, input logic [7:0] b, input bit stop_ok, input bit par_ok);
    int r0, f0, p0, o0;
    int e_req, e_fe, e_pe, e_ov;
    r0 = n_req_rise; f0 = n_fe; p0 = n_pe; o0 = n_ov;
    e_req = 0; e_fe = 0; e_pe = 0; e_ov = 0;
    if (!stop_ok)                e_fe = 1;
    else if (PAR && !par_ok)     e_pe = 1;
    else if (model_pending)      e_ov = 1;
    else begin
      e_req = 1;
      model_data = b;
      model_pending = !bus.ack;
    end
    send_raw(b, par_ok ? ^b : ~^b, stop_ok);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_req"},       n_req_rise - r0, e_req);
    check({tag, "_frame_err"}, n_fe - f0,       e_fe);
    check({tag, "_parity_err"},n_pe - p0,       e_pe);
    check({tag, "_overrun"},   n_ov - o0,       e_ov);
  endtask

  task automatic ack_pulse();
    bus.ack = 1'b1;
    @(posedge clk);
    #1;
    bus.ack = 1'b0;
    model_pending = 1'b0;
  endtask

  initial begin
    int start_cycle, rc0, ev0, rise0;
    bus.rx  = 1'b1;
    bus.ack = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("post_reset_req",  {31'd0, bus.req}, 32'd0);
    check("post_reset_data", {24'd0, bus.data}, 32'h00);
    idle(5);

    // 0xA5 with ack tied high: one-cycle req, correct byte, latency near nominal
    bus.ack = 1'b1;
    start_cycle = cycle;
    rc0 = n_req_cycles;
    do_frame("a5", 8'hA5, 1'b1, 1'b1);
    check("a5_req_width", n_req_cycles - rc0, 1);
    check("a5_data", {24'd0, bus.data}, 32'hA5);
    check("a5_latency_window",
          {31'd0, (last_rise_cycle - start_cycle >= EXP_LAT - 2) &&
                  (last_rise_cycle - start_cycle <= EXP_LAT + 3)}, 32'd1);
    bus.ack = 1'b0;
    idle(5);

    // 0x3C held, 0x81 overruns, data stays 0x3C; ack drops req on the next edge
    do_frame("3c", 8'h3C, 1'b1, 1'b1);
    check("3c_req_held", {31'd0, bus.req}, 32'd1);
    check("3c_data", {24'd0, bus.data}, 32'h3C);
    do_frame("81_overrun", 8'h81, 1'b1, 1'b1);
    check("81_data_kept", {24'd0, bus.data}, 32'h3C);
    bus.ack = 1'b1;
    @(negedge clk);
    check("ack_req_still_high", {31'd0, bus.req}, 32'd1);
    @(negedge clk);
    check("ack_req_fallen", {31'd0, bus.req}, 32'd0);
    @(posedge clk);
    #1;
    bus.ack = 1'b0;
    model_pending = 1'b0;
    idle(5);

    // 0x55 with low stop bit, line held low 30 more cycles, then 0x12
    do_frame("55_frame", 8'h55, 1'b0, 1'b1);
    ev0 = total_events();
    bus.rx = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    idle(8);
    check("break_no_events", total_events() - ev0, 0);
    do_frame("12", 8'h12, 1'b1, 1'b1);
    check("12_data", {24'd0, bus.data}, 32'h12);
    ack_pulse();
    idle(5);

    // 3-cycle glitch on an idle line
    ev0 = total_events();
    bus.rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(20);
    check("glitch_no_events", total_events() - ev0, 0);

`ifdef SERIAL_RX_PARITY_EN
    do_frame("07_par_ok", 8'h07, 1'b1, 1'b1);
    check("07_data", {24'd0, bus.data}, 32'h07);
    ack_pulse();
    idle(5);
    do_frame("07_par_bad", 8'h07, 1'b1, 1'b0);
    check("07_bad_no_req", {31'd0, bus.req}, 32'd0);
    idle(5);
`endif

    // Pending byte, then reset mid-DATA of 0xF0, then 0x0F is the only delivery
    do_frame("99", 8'h99, 1'b1, 1'b1);
    check("99_req_pending", {31'd0, bus.req}, 32'd1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_req",  {31'd0, bus.req}, 32'd0);
    check("rst_mid_data", {24'd0, bus.data}, 32'h00);
    repeat (2) @(posedge clk);
    #1;
    bus.rx = 1'b1;
    rst = 1'b0;
    model_data = 8'h00;
    model_pending = 1'b0;
    rise0 = n_req_rise;
    idle(20);
    check("after_rst_no_req", n_req_rise - rise0, 0);
    do_frame("0f", 8'h0F, 1'b1, 1'b1);
    check("0f_data", {24'd0, bus.data}, 32'h0F);
    check("0f_only_delivery", n_req_rise - rise0, 1);
    idle(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_receiver.md
# serial_receiver

UART-style asynchronous serial receiver (8 data bits, LSB first, 1 stop bit, optional even parity). It is the receive counterpart of `serial_transmitter` and sits on the same 50 MHz system clock. Bytes arriving on `rx` are presented to downstream logic over the same `req`/`data`/`ack` handshake the transmitter consumes. Framing errors, parity errors and overruns are reported as single-cycle pulses.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line bit rate.
- Derived constants: `CLKS_PER_BIT = CLK_HZ / BAUD` (integer division; 434 at defaults) and `HALF_BIT = CLKS_PER_BIT / 2`. `CLKS_PER_BIT` must be ≥ 4; elaboration error otherwise.

- `clk`: in, 1. Single system clock; all logic on its rising edge.
- `rst`: in, 1. Asynchronous, active-high reset.
- `rx`: in, 1. Asynchronous serial line; idles high.
- `req`: out, 1. A received byte is valid on `data`.
- `data`: out, 8. Received byte; stable while `req` is high.
- `ack`: in, 1. Consumer accepts the byte. A transfer completes on any cycle where `req && ack`.
- `frame_err`: out, 1. One-cycle pulse: stop bit sampled low.
- `parity_err`: out, 1. One-cycle pulse: parity mismatch. Tied 0 when parity is compiled out.
- `overrun`: out, 1. One-cycle pulse: a byte completed while `req` was still high.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`. All decisions use `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK. A bit-timer counts `0..CLKS_PER_BIT-1`; a 3-bit index counts data bits.
- IDLE → START on `rx_s == 0`; timer cleared.
- START:
  - At `HALF_BIT`: if `rx_s == 1` it is a false start → IDLE.
  - Otherwise → DATA; timer restarts so that subsequent samples land at bit centres.
- DATA:
  - Every `CLKS_PER_BIT` cycles, shift `rx_s` into bit `[index]` of the shift register (LSB first).
  - After bit 7 → PARITY if compiled in, else → STOP.
- PARITY: sample one bit at its centre. Store mismatch against even parity over the 8 data bits. → STOP.
- STOP: sample at the stop-bit centre.
  - `rx_s == 1` and no parity mismatch:
    - If `req == 0`: load `data`, set `req`.
    - If `req == 1` (including a same-cycle `ack`): pulse `overrun`, drop the new byte, leave `data` unchanged.
    - → IDLE.
  - `rx_s == 1` and parity mismatch: pulse `parity_err`, discard the byte → IDLE.
  - `rx_s == 0`: pulse `frame_err`, discard the byte → BREAK.
- BREAK: wait for `rx_s == 1`, then → IDLE. This prevents re-triggering on a held-low line.
- Handshake:
  - `req` clears on the cycle after `req && ack`.
  - `ack` while `req == 0` is ignored.
  - `data` is held until the next accepted byte.

## Timing
- Reset values: state IDLE, `req = 0`, `data = 8'h00`, `frame_err = 0`, `parity_err = 0`, `overrun = 0`, timer 0, shift register 0.
- Reset mid-frame aborts the frame immediately; any pending `req` is lost.
- Latency: `req` rises 1 cycle after the stop-bit centre sample. That is ≈ `2 + HALF_BIT + (9 or 10)·CLKS_PER_BIT + 1` cycles after the `rx` falling edge (2 synchronizer cycles; 9 bit periods without parity, 10 with).
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start edge arriving half a bit later is caught. Tolerated baud mismatch is ±2 %.
- Error and overrun pulses are exactly 1 cycle wide, coincident with the stop-bit sample cycle +1.
- Throughput: one byte per frame. The consumer must ack within one frame time to avoid overrun.

## Configuration
- `SERIAL_RX_PARITY_EN` defined:
  - The frame carries an even-parity bit between data bit 7 and the stop bit.
  - PARITY state is present and `parity_err` is active.
- Not defined:
  - 8N1 framing; the PARITY state is omitted.
  - `parity_err` is tied 0.

## Test plan
- `CLK_HZ=1000`, `BAUD=100` (10 clocks/bit), 8N1. Send 0xA5 with `ack` tied high → `req` pulses 1 cycle, `data == 8'hA5`, no error pulses.
- Send 0x3C with `ack` held low, then send 0x81 → `overrun` pulses once and `data` stays 0x3C. Assert `ack` → `req` falls the next cycle.
- Send 0x55 with the stop bit driven low → `frame_err` pulse, no `req`. Hold `rx` low for 30 cycles, then release, then send 0x12 → `data == 8'h12`.
- Drive a 3-cycle low glitch on an idle line → no `req`, no errors, FSM back in IDLE.
- With `SERIAL_RX_PARITY_EN`: send 0x07 with parity 1 → `data == 8'h07`. Send 0x07 with parity 0 → `parity_err` pulse, no `req`.
- Assert `rst` during DATA of 0xF0, release, then send 0x0F → only 0x0F is delivered and all outputs are 0 during reset.
